// File: rtl/rsa_modexp_decrypt_if.sv
// Request/response bundle between the decrypt core and its requester.
// Carries the key material, the ciphertext and the completion status.
interface rsa_modexp_decrypt_if #(
  parameter int W = 12
);
  logic         start;
  logic         key_valid;
  logic [W-1:0] d;
  logic [W-1:0] n;
  logic [W-1:0] c;
  logic [W-1:0] m;
  logic         busy;
  logic         done;
  logic         err;

  modport master (
    output start, key_valid, d, n, c,
    input  m, busy, done, err
  );

  modport slave (
    input  start, key_valid, d, n, c,
    output m, busy, done, err
  );
endinterface

// File: rtl/rsa_modexp_decrypt.sv
// Fixed-latency RSA decrypt: m = c^d mod n using right-to-left
// square-and-multiply with interleaved shift-add modular multipliers.
module rsa_modexp_decrypt #(
  parameter int W = 12
) (
  input logic               clk,
  input logic               rst_n,
  rsa_modexp_decrypt_if.slave bus
);
  localparam int CW = $clog2(W);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] MUL  = 3'd2;
  localparam logic [2:0] UPD  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]    state;
  logic [W-1:0]  nr;
  logic [W-1:0]  res;
  logic [W-1:0]  base;
  logic [W-1:0]  e;
  logic [W-1:0]  acc1;
  logic [W-1:0]  acc2;
  logic [CW-1:0] k;
  logic [CW-1:0] j;
  logic [CW-1:0] bidx;
  logic          bbit;
  logic [W-1:0]  nxt1;
  logic [W-1:0]  nxt2;
  logic [W-1:0]  m_r;
  logic          busy_r;
  logic          done_r;
  logic          err_r;
  logic          bad;

  // One shift-add step; W+1 bits suffice since acc, a < mod.
  function automatic logic [W-1:0] mstep(
    input logic [W-1:0] acc,
    input logic [W-1:0] a,
    input logic         b,
    input logic [W-1:0] mod
  );
    logic [W:0] t;
    logic [W:0] nz;
    nz = {1'b0, mod};
    t  = {acc, 1'b0};
    if (t >= nz) t = t - nz;
    if (b) begin
      t = t + {1'b0, a};
      if (t >= nz) t = t - nz;
    end
    return t[W-1:0];
  endfunction

  always_comb begin
    bidx = CW'(W - 1) - j;
    bbit = base[bidx];
    nxt1 = mstep(acc1, res, bbit, nr);
    nxt2 = mstep(acc2, base, bbit, nr);
    bad  = !bus.key_valid
        || (bus.n < W'(2))
        || (bus.c >= bus.n);
  end

  assign bus.m    = m_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.err  = err_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      nr     <= '0;
      res    <= '0;
      base   <= '0;
      e      <= '0;
      acc1   <= '0;
      acc2   <= '0;
      k      <= '0;
      j      <= '0;
      m_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            nr   <= bus.n;
            base <= bus.c;
            e    <= bus.d;
            if (bad) begin
              state  <= DONE;
              done_r <= 1'b1;
              err_r  <= 1'b1;
              m_r    <= '0;
            end else begin
              state  <= LOAD;
              busy_r <= 1'b1;
              err_r  <= 1'b0;
            end
          end
        end
        LOAD: begin
          res   <= W'(1);
          k     <= '0;
          j     <= '0;
          acc1  <= '0;
          acc2  <= '0;
          state <= MUL;
        end
        MUL: begin
          acc1 <= nxt1;
          acc2 <= nxt2;
          j    <= j + 1'b1;
          if (j == CW'(W - 1)) state <= UPD;
        end
        UPD: begin
          if (e[0]) res <= acc1;
          base <= acc2;
          e    <= e >> 1;
          k    <= k + 1'b1;
          j    <= '0;
          acc1 <= '0;
          acc2 <= '0;
          if (k == CW'(W - 1)) begin
            state  <= DONE;
            done_r <= 1'b1;
            m_r    <= e[0] ? acc1 : res;
          end else begin
            state <= MUL;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_modexp_decrypt.sv
// Directed and random-key checks of the RSA decrypt core
// against a plain-arithmetic modular exponent model.
module tb_rsa_modexp_decrypt;
  localparam int W   = 12;
  localparam int LAT = 1 + W * (W + 1);

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  rsa_modexp_decrypt_if #(.W(W)) bus ();

  rsa_modexp_decrypt #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int powmod(input int b, input int x, input int md);
    longint r;
    r = 1 % md;
    for (int i = 0; i < x; i++) r = (r * b) % md;
    return int'(r);
  endfunction

  function automatic int gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one request; lat counts edges after the accept edge.
  task automatic op(
    input  int dd, input int nn, input int cc, input logic kv,
    input  logic exp_busy,
    output int om, output int oerr, output int lat,
    output int busy_ok, output int post_ok
  );
    bus.d         = W'(dd);
    bus.n         = W'(nn);
    bus.c         = W'(cc);
    bus.key_valid = kv;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    lat       = -1;
    busy_ok   = 1;
    om        = -1;
    oerr      = -1;
    for (int i = 0; i < LAT + 40; i++) begin
      if (bus.busy !== exp_busy) busy_ok = 0;
      if (bus.done === 1'b1) begin
        lat  = i;
        om   = int'(bus.m);
        oerr = int'(bus.err);
        break;
      end
      tick();
    end
    tick();
    post_ok = (bus.done === 1'b0 && bus.busy === 1'b0) ? 1 : 0;
  endtask

  int om, oerr, lat, bok, pok;
  int pulses, mseen, first;
  int primes[$];
  int p, q, nn, phi, ee, dd, msg, ct;
  logic pr;

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.key_valid = 1'b0;
    bus.d         = '0;
    bus.n         = '0;
    bus.c         = '0;
    tick();
    tick();
    chk("rst_m", int'(bus.m), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    rst_n = 1'b1;
    tick();

    op(103, 143, 48, 1'b1, 1'b1, om, oerr, lat, bok, pok);
    chk("base_m", om, 9);
    chk("base_model", om, powmod(48, 103, 143));
    chk("base_err", oerr, 0);
    chk("base_lat", lat, LAT);
    chk("base_busy", bok, 1);
    chk("base_post", pok, 1);

    op(10, 1000, 2, 1'b1, 1'b1, om, oerr, lat, bok, pok);
    chk("n1000_m", om, 24);
    chk("n1000_lat", lat, LAT);
    op(0, 1000, 5, 1'b1, 1'b1, om, oerr, lat, bok, pok);
    chk("d0_m", om, 1);
    op(103, 143, 0, 1'b1, 1'b1, om, oerr, lat, bok, pok);
    chk("c0_m", om, 0);
    op(4094, 4095, 1, 1'b1, 1'b1, om, oerr, lat, bok, pok);
    chk("c1_m", om, 1);
    op(4093, 4095, 4094, 1'b1, 1'b1, om, oerr, lat, bok, pok);
    chk("nmax_m", om, powmod(4094, 4093, 4095));
    op(103, 143, 48, 1'b1, 1'b1, om, oerr, lat, bok, pok);
    chk("pre_err_m", om, 9);

    op(103, 143, 143, 1'b1, 1'b0, om, oerr, lat, bok, pok);
    chk("ceqn_err", oerr, 1);
    chk("ceqn_m", om, 0);
    chk("ceqn_lat", lat, 0);
    chk("ceqn_busy", bok, 1);
    chk("ceqn_post", pok, 1);
    op(5, 1, 0, 1'b1, 1'b0, om, oerr, lat, bok, pok);
    chk("n1_err", oerr, 1);
    chk("n1_lat", lat, 0);
    chk("n1_busy", bok, 1);
    op(103, 143, 48, 1'b0, 1'b0, om, oerr, lat, bok, pok);
    chk("kv0_err", oerr, 1);
    chk("kv0_m", om, 0);
    chk("kv0_lat", lat, 0);
    chk("kv0_busy", bok, 1);

    // Start held high with changing operands while busy.
    bus.d         = W'(103);
    bus.n         = W'(143);
    bus.c         = W'(48);
    bus.key_valid = 1'b1;
    bus.start     = 1'b1;
    tick();
    pulses = 0;
    mseen  = -1;
    first  = -1;
    for (int i = 0; i < LAT + 40; i++) begin
      if (i < 30) begin
        bus.d = W'($urandom_range(0, 4095));
        bus.n = W'($urandom_range(2, 4095));
        bus.c = W'($urandom_range(0, 1));
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = i;
          mseen = int'(bus.m);
        end
      end
      tick();
    end
    chk("ign_pulses", pulses, 1);
    chk("ign_m", mseen, 9);
    chk("ign_lat", first, LAT);

    // Reset asserted at edge 50 of a run.
    bus.d     = W'(103);
    bus.n     = W'(143);
    bus.c     = W'(48);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i < 50; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_m", int'(bus.m), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < LAT + 20; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
      tick();
    end
    chk("mid_rst_quiet", pulses, 0);
    op(103, 143, 48, 1'b1, 1'b1, om, oerr, lat, bok, pok);
    chk("after_rst_m", om, 9);
    chk("after_rst_lat", lat, LAT);

    // Random RSA keys from small primes.
    for (int v = 2; v < 2048; v++) begin
      pr = 1'b1;
      for (int f = 2; f * f <= v; f++) if (v % f == 0) pr = 1'b0;
      if (pr) primes.push_back(v);
    end
    for (int it = 0; it < 200; it++) begin
      do begin
        p = primes[$urandom_range(0, primes.size() - 1)];
        q = primes[$urandom_range(0, primes.size() - 1)];
      end while (p == q || p * q >= 4096);
      nn  = p * q;
      phi = (p - 1) * (q - 1);
      do ee = int'($urandom_range(1, phi - 1));
      while (gcd(ee, phi) != 1);
      dd = 1;
      for (int x = 1; x <= phi; x++) begin
        if ((ee * x) % phi == 1 % phi) begin
          dd = x;
          break;
        end
      end
      msg = int'($urandom_range(0, nn - 1));
      ct  = powmod(msg, ee, nn);
      op(dd, nn, ct, 1'b1, 1'b1, om, oerr, lat, bok, pok);
      chk($sformatf("rnd%0d_m n=%0d d=%0d c=%0d", it, nn, dd, ct), om, msg);
      chk($sformatf("rnd%0d_lat", it), lat, LAT);
      chk($sformatf("rnd%0d_err", it), oerr, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/rsa_modexp_decrypt.md
Name: rsa_modexp_decrypt

Overview:
- Downstream consumer of the private-key generator in the public-key decryption datapath.
- Takes the generated private exponent d, its valid flag, the modulus n and a ciphertext word c. Computes m = c^d mod n.
- Uses fixed-latency square-and-multiply. Each modular multiply is an interleaved shift-add, so no divider or wide multiplier is needed.
- Returns the plaintext with a one-cycle done pulse.

Parameters:
- W, 12, operand width of d, n, c and m; matches the key generator's 12-bit datapath.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- key_valid  input  1  private exponent valid; driven by the key generator's flag.
- d  input  W  private exponent.
- n  input  W  modulus (p*q).
- c  input  W  ciphertext.
- m  output  W  plaintext result; held until the next accepted start.
- busy  output  1  high from the accept edge until done.
- done  output  1  one-cycle completion pulse.
- err  output  1  qualifies done; high when the request was rejected.

Behaviour:
- Reset: clk and reset only; synchronous, active-low. While rst_n=0 at an edge: state=IDLE, m=0, busy=0, done=0, err=0, all internal registers cleared.
- Reset mid-operation aborts the calculation with no done pulse.
- Start acceptance:
  - Edge 0 is the edge where start=1 in IDLE. d, n, c are latched at edge 0; later input changes are ignored.
  - start is ignored while busy or during the DONE cycle.
- Error check, evaluated at edge 0: key_valid=0, or n<2, or c>=n.
  - Go to DONE directly.
  - done=1, err=1 and m=0 for the cycle after edge 0.
  - busy stays 0.
- States:
  - IDLE -> LOAD (valid start).
  - LOAD: 1 cycle. res=1, base=c, e=d, bit counter k=0.
  - MUL: W cycles, per-bit multiplier counter.
  - UPD: 1 cycle.
  - After UPD, go back to MUL if k<W-1, else go to DONE.
  - DONE: 1 cycle -> IDLE.
- Exponent loop:
  - Right-to-left over all W bits of d, LSB first. There is no early exit, so latency is data-independent.
  - In MUL, two modular multipliers run in parallel: P1 = res*base mod n and P2 = base*base mod n.
  - In UPD: res <= P1 if e[0]=1, else res is unchanged; base <= P2; e <= e>>1; k <= k+1.
- Modular multiply a*b mod n (a, b < n):
  - acc=0.
  - For each bit of b, MSB first, one bit per cycle: t = 2*acc; if t>=n then t = t-n. If the b bit is 1: t = t+a; if t>=n then t = t-n. acc <= t.
  - Intermediates are W+1 bits wide. At most one conditional subtract per step, so acc<n always.
- Timing:
  - busy=1 from after edge 0 through the end of the DONE cycle.
  - done=1 for exactly one cycle, starting after edge 1+W*(W+1), which is edge 157 for W=12.
  - m updates on the same edge done rises; err=0 on success.
- Edge cases:
  - d=0 gives m=1.
  - c=0 with d>0 gives m=0.
  - c=1 gives m=1.
  - n is the full W-bit range up to 4095, with no overflow.
- Back-to-back: a new start is accepted in the IDLE cycle immediately following DONE.

Test Plan:
- Key p=11, q=13: n=143, d=103 (e=7, totient=120), c=48, key_valid=1, pulse start -> done exactly at edge 157, m=9, err=0, busy high edges 1..157.
- n=1000, d=10, c=2 -> m=24. Then d=0, c=5 -> m=1. Then c=0, d=103, n=143 -> m=0.
- Error paths: c=143 with n=143; n=1; key_valid=0 -> each gives done=1 and err=1 on the cycle after start, m=0, busy never asserted.
- Start re-asserted and d, n, c changed while busy -> ignored; first result (m=9) is unaffected; one done pulse only.
- rst_n=0 at edge 50 of the n=143 run -> next cycle IDLE with m=0, busy=0, and no done. A new start then completes normally with m=9.
- Random sweep: 200 random primes p, q with p*q<4096, e coprime to the totient, d = e^-1 mod totient, random m<n, c = m^e mod n -> decrypted m matches the reference model, and latency is always 157.
